// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port request arbiter and sequencer in front of the single-port data_mem
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (port 0 always wins ties instead of round-robin)
module data_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic              grant_any;
    logic              grant_port;
    logic              accept;
    logic              rsp_take;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Tie-break: port 0 always wins when both ports request.
    always_comb begin
        grant_any  = p0_req_valid | p1_req_valid;
        grant_port = ~p0_req_valid;
    end
`else
    // last_grant holds the port id of the most recent accepted request;
    // resetting it to 1 lets port 0 win the first tie.
    logic last_grant_q;

    // Tie-break: the port that did not win last time takes the grant.
    always_comb begin
        grant_any  = p0_req_valid | p1_req_valid;
        grant_port = p1_req_valid;
        if (p0_req_valid && p1_req_valid) begin
            grant_port = ~last_grant_q;
        end
    end

    // Remember the most recently accepted port for the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant_port;
        end
    end
`endif

    assign accept   = (state_q == IDLE) && grant_any;
    assign rsp_take = owner_q ? p1_rsp_ready : p0_rsp_ready;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; mem_write is only ever high in ACCESS.
    always_comb begin
        state_d      = state_q;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        mem_write    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    p0_req_ready = ~grant_port;
                    p1_req_ready = grant_port;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                mem_write = we_q;
                state_d   = we_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                p0_rsp_valid = ~owner_q;
                p1_rsp_valid = owner_q;
                if (rsp_take) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latches double as the memory address/data drivers, so they
    // hold their last values outside ACCESS/CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (accept) begin
            owner_q     <= grant_port;
            we_q        <= grant_port ? p1_we    : p0_we;
            mem_addr_q  <= grant_port ? p1_addr  : p0_addr;
            mem_wdata_q <= grant_port ? p1_wdata : p0_wdata;
        end
    end

    // Per-port response data: zero for writes, captured memory word for reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else if (state_q == ACCESS && we_q) begin
            if (owner_q) begin
                p1_rdata_q <= '0;
            end else begin
                p0_rdata_q <= '0;
            end
        end else if (state_q == CAPTURE) begin
            if (owner_q) begin
                p1_rdata_q <= mem_rdata;
            end else begin
                p0_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic              p0_req_ready, p1_req_ready;
    logic              p0_we = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
    logic              p0_rsp_valid, p1_rsp_valid;
    logic              p0_rsp_ready = 1'b0, p1_rsp_ready = 1'b0;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rdata(p0_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for data_mem: asynchronous read, write at the clock edge.
    logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr] <= mem_wdata;
    end

    // Reference model: transaction-level memory image and tie-break memory.
    logic [DATA_W-1:0] ref_mem [int];
    int                last_grant_m = 1;

    // Pending requester-side transactions.
    bit                pend_v  [2];
    bit                pend_we [2];
    logic [ADDR_W-1:0] pend_a  [2];
    logic [DATA_W-1:0] pend_d  [2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive pins from the pending table; idle ports get garbage fields.
    task automatic apply();
        p0_req_valid = pend_v[0];
        p0_we        = pend_v[0] ? pend_we[0] : 1'($urandom);
        p0_addr      = pend_v[0] ? pend_a[0]  : ADDR_W'($urandom);
        p0_wdata     = pend_v[0] ? pend_d[0]  : $urandom;
        p1_req_valid = pend_v[1];
        p1_we        = pend_v[1] ? pend_we[1] : 1'($urandom);
        p1_addr      = pend_v[1] ? pend_a[1]  : ADDR_W'($urandom);
        p1_wdata     = pend_v[1] ? pend_d[1]  : $urandom;
    endtask

    task automatic post(input int p, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pend_v[p] = 1'b1; pend_we[p] = we; pend_a[p] = a; pend_d[p] = d;
    endtask

    function automatic logic rv(input int p);
        return p != 0 ? p1_rsp_valid : p0_rsp_valid;
    endfunction

    function automatic logic [DATA_W-1:0] rd(input int p);
        return p != 0 ? p1_rdata : p0_rdata;
    endfunction

    // Serve one transaction from the pending table; called at posedge+1.
    task automatic serve(input int hold, output int w);
        int                exp_w;
        bit                we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
        bit                known;
        logic [DATA_W-1:0] snap;
        if (pend_v[0] && pend_v[1]) exp_w = FIXED ? 0 : 1 - last_grant_m;
        else                        exp_w = pend_v[0] ? 0 : 1;
        apply();
        #1;
        for (int i = 0; i < 20; i++) begin
            if (p0_req_ready || p1_req_ready) break;
            @(posedge clk); #1;
        end
        chk("ready_seen", {p0_req_ready | p1_req_ready}, 64'd1);
        w = p1_req_ready ? 1 : 0;
        chk("grant_port", 64'(w), 64'(exp_w));
        chk("ready_onehot", {p0_req_ready & p1_req_ready}, 64'd0);
        we = pend_we[w]; a = pend_a[w]; d = pend_d[w];
        last_grant_m = w;
        @(posedge clk); #1;
        pend_v[w] = 1'b0;
        apply();
        chk("acc_mem_write", {mem_write}, {we});
        chk("acc_mem_addr", 64'(mem_addr), 64'(a));
        if (we) chk("acc_mem_wdata", 64'(mem_wdata), 64'(d));
        chk("acc_quiet", {p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready}, 64'd0);
        if (we) ref_mem[int'(a)] = d;
        @(posedge clk); #1;
        chk("edge2_mem_write", {mem_write}, 64'd0);
        chk("edge2_rsp", {rv(w)}, {we});
        if (!we) begin
            @(posedge clk); #1;
            chk("edge3_rsp", {rv(w)}, 64'd1);
        end
        chk("other_rsp", {rv(1 - w)}, 64'd0);
        chk("resp_mem_addr", 64'(mem_addr), 64'(a));
        known = we || ref_mem.exists(int'(a));
        exp_rd = we ? '0 : (known ? ref_mem[int'(a)] : '0);
        if (known) chk("rsp_rdata", 64'(rd(w)), 64'(exp_rd));
        snap = rd(w);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_state", {rv(w), rd(w), p0_req_ready, p1_req_ready}, {1'b1, snap, 2'b00});
        end
        if (w != 0) p1_rsp_ready = 1'b1; else p0_rsp_ready = 1'b1;
        @(posedge clk); #1;
        p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
        chk("rsp_drop", {rv(w)}, 64'd0);
    endtask

    logic [ADDR_W-1:0] pool [8];
    int                w;

    initial begin
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        #2;
        chk("reset_outs", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, mem_write}, 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_rdata", {p0_rdata, p1_rdata}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Write from port 0, then read it back through port 1.
        post(0, 1'b1, 11'h001, 32'hDEADBEEF); serve(0, w);
        post(1, 1'b0, 11'h001, '0);            serve(0, w);

        // Contending reads with both ports held valid.
        post(0, 1'b1, 11'h010, 32'h1111_0010); serve(0, w);
        post(1, 1'b1, 11'h020, 32'h2222_0020); serve(0, w);
        post(0, 1'b0, 11'h010, '0);
        post(1, 1'b0, 11'h020, '0);
        for (int g = 0; g < 4; g++) begin
            serve(0, w);
            post(w, 1'b0, w != 0 ? 11'h020 : 11'h010, '0);
        end
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;

        // Back-pressured response while the other port keeps requesting.
        post(0, 1'b0, 11'h010, '0);
        post(1, 1'b1, 11'h030, 32'h3333_0030);
        serve(5, w);
        serve(1, w);

        // Reset in the middle of a write access.
        post(0, 1'b1, 11'h7FF, 32'h0AAAAAAA);
        apply(); #1;
        chk("rst_pre_ready", {p0_req_ready}, 64'd1);
        @(posedge clk); #1;
        chk("rst_pre_write", {mem_write}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_write", {mem_write}, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        pend_v[0] = 1'b0; apply();
        @(posedge clk); #1;
        rst = 1'b0;
        last_grant_m = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst_no_rsp", {p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready}, 64'd0);
        end

        // Address extremes.
        post(1, 1'b1, 11'h000, 32'hA5A5_0000); serve(0, w);
        post(0, 1'b1, 11'h7FF, 32'h5A5A_07FF); serve(0, w);
        post(0, 1'b0, 11'h000, '0);            serve(0, w);
        post(1, 1'b0, 11'h7FF, '0);            serve(0, w);

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 8; i++) begin
            pool[i] = ADDR_W'($urandom);
            post(i % 2, 1'b1, pool[i], $urandom);
            serve(0, w);
        end
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend_v[p] && ($urandom_range(0, 1) == 1))
                    post(p, 1'($urandom), pool[$urandom_range(0, 7)], $urandom);
            end
            if (!pend_v[0] && !pend_v[1])
                post($urandom_range(0, 1), 1'($urandom), pool[$urandom_range(0, 7)], $urandom);
            serve($urandom_range(0, 2), w);
        end
        while (pend_v[0] || pend_v[1]) serve(0, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
